// File: rtl/arb_pkg.sv
// Shared definitions for the two-master data-bus arbiter: FSM encoding and master IDs.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

  localparam logic MID_CORE   = 1'b0;
  localparam logic MID_LOADER = 1'b1;
  localparam int   NUM_MASTERS = 2;

endpackage

// File: rtl/arb_rd_tracker.sv
// Tracks the single in-flight read and steers the slave's next-cycle read data
// back to the master that issued it.
module arb_rd_tracker
  import arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  rd_accept,
  input  logic                  rd_owner,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata
);

  logic rd_pend;
  logic rd_id;
  logic [NUM_MASTERS-1:0]                 rvalid;
  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0] rdata;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_pend <= 1'b0;
      rd_id   <= MID_CORE;
    end else begin
      rd_pend <= rd_accept;
      if (rd_accept) rd_id <= rd_owner;
    end
  end

  // Data is forced to zero for any master not receiving a response this cycle.
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_ret
    assign rvalid[g] = rd_pend & (rd_id == 1'(g));
    assign rdata[g]  = rvalid[g] ? s_rdata : '0;
  end

  assign m0_rvalid = rvalid[0];
  assign m0_rdata  = rdata[0];
  assign m1_rvalid = rvalid[1];
  assign m1_rdata  = rdata[1];

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master data-bus arbiter (core vs. loader/DMA) with a burst cap that
// alternates ownership fairly when both masters keep requesting.
module data_bus_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  s_req,
  output logic                  s_we,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [DATA_WIDTH-1:0] s_wdata,
  input  logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_MAX  = CW'(MAX_BURST);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  arb_state_e    state, state_nxt;
  logic          last_owner;
  logic [CW-1:0] burst_cnt;
  logic          accept;
  logic          owner_id;
  logic          burst_done;

  assign accept     = s_req & s_ready;
  assign burst_done = accept & (burst_cnt >= BURST_LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= ARB_IDLE;
      last_owner <= MID_LOADER;
      burst_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        burst_cnt <= '0;
        if (state == ARB_OWN0) last_owner <= MID_CORE;
        else if (state == ARB_OWN1) last_owner <= MID_LOADER;
      end else if (accept && burst_cnt != BURST_MAX) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (m0_req && m1_req) state_nxt = (last_owner == MID_LOADER) ? ARB_OWN0 : ARB_OWN1;
        else if (m0_req)      state_nxt = ARB_OWN0;
        else if (m1_req)      state_nxt = ARB_OWN1;
      end
      ARB_OWN0: begin
        if (!m0_req)                 state_nxt = m1_req ? ARB_OWN1 : ARB_IDLE;
        else if (burst_done && m1_req) state_nxt = ARB_OWN1;
      end
      ARB_OWN1: begin
        if (!m1_req)                 state_nxt = m0_req ? ARB_OWN0 : ARB_IDLE;
        else if (burst_done && m0_req) state_nxt = ARB_OWN0;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    s_req    = 1'b0;
    s_we     = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    m0_gnt   = 1'b0;
    m1_gnt   = 1'b0;
    owner_id = MID_CORE;
    case (state)
      ARB_OWN0: begin
        s_req   = m0_req;
        s_we    = m0_we;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        m0_gnt  = m0_req & s_ready;
      end
      ARB_OWN1: begin
        s_req    = m1_req;
        s_we     = m1_we;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        m1_gnt   = m1_req & s_ready;
        owner_id = MID_LOADER;
      end
      default: ;
    endcase
  end

  arb_rd_tracker #(.DATA_WIDTH(DATA_WIDTH)) u_rd_tracker (
    .clk       (clk),
    .n_rst     (n_rst),
    .rd_accept (accept & ~s_we),
    .rd_owner  (owner_id),
    .s_rdata   (s_rdata),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata)
  );

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: reset, reads, contention, stall, hand-off, solo tenure.
module tb_data_bus_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_we, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;

  int checks   = 0;
  int failures = 0;

  data_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_all;
    m0_req = 1'b0; m1_req = 1'b0; s_ready = 1'b1;
    tick; tick;
  endtask

  task automatic test_reset;
    n_rst = 1'b0; s_ready = 1'b1; s_rdata = 32'h0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'hA000_0000; m0_wdata = 32'h1111_1111;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hB000_0000; m1_wdata = 32'h2222_2222;
    tick; tick;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_req, s_we} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000000", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, s_req, s_we});
    end
    checks++;
    if ({s_addr, s_wdata, m0_rdata, m1_rdata} !== 128'h0) begin
      failures++; $display("FAIL reset_data got=%h %h %h %h exp=0", s_addr, s_wdata, m0_rdata, m1_rdata);
    end
    tick; n_rst = 1'b1;
    @(negedge clk);
    checks++;
    if (s_req !== 1'b0) begin failures++; $display("FAIL reset_arb_latency s_req got=%b exp=0", s_req); end
    tick;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10 || s_addr !== 32'hA000_0000) begin
      failures++; $display("FAIL reset_first_tie gnt=%b addr=%h exp=10 a0000000", {m0_gnt, m1_gnt}, s_addr);
    end
    tick;
    idle_all;
  endtask

  task automatic test_single_read;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0010;
    tick;
    @(negedge clk);
    checks++;
    if ({m1_gnt, m0_gnt, s_we} !== 3'b100 || s_addr !== 32'h10) begin
      failures++; $display("FAIL read_gnt gnt1/gnt0/we=%b addr=%h exp=100 10", {m1_gnt, m0_gnt, s_we}, s_addr);
    end
    tick; m1_req = 1'b0; s_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL read_data rvalid=%b rdata=%h exp=1 deadbeef", m1_rvalid, m1_rdata);
    end
    checks++;
    if (m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
      failures++; $display("FAIL read_other rvalid=%b rdata=%h exp=0 0", m0_rvalid, m0_rdata);
    end
    tick;
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
      failures++; $display("FAIL read_one_cycle rvalid=%b rdata=%h exp=0 0", m1_rvalid, m1_rdata);
    end
    tick;
    idle_all;
  endtask

  task automatic test_contention;
    logic exp0;
    m0_req = 1'b1; m0_we = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick;
      @(negedge clk);
      exp0 = ((k / 4) % 2) == 0;
      checks++;
      if ({m0_gnt, m1_gnt} !== {exp0, ~exp0}) begin
        failures++; $display("FAIL contention_cyc%0d gnt0/gnt1=%b exp=%b", k, {m0_gnt, m1_gnt}, {exp0, ~exp0});
      end
    end
    tick;
    idle_all;
  endtask

  task automatic test_stall;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'h1234_5678;
    m1_req = 1'b1; m1_we = 1'b1; s_ready = 1'b0;
    tick;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (m0_gnt !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'h40 || s_wdata !== 32'h1234_5678) begin
        failures++; $display("FAIL stall_cyc%0d gnt=%b req=%b addr=%h wdata=%h exp=0 1 40 12345678",
                             i, m0_gnt, s_req, s_addr, s_wdata);
      end
      tick;
    end
    s_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({m0_gnt, m1_gnt} !== {k < 4, k == 4}) begin
        failures++; $display("FAIL stall_burst_cyc%0d gnt0/gnt1=%b exp=%b", k, {m0_gnt, m1_gnt}, {k < 4, k == 4});
      end
      tick;
    end
    idle_all;
  endtask

  task automatic test_handoff;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h50;
    m1_we = 1'b1; m1_addr = 32'h60;
    tick;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin failures++; $display("FAIL handoff_own0 gnt=%b exp=1", m0_gnt); end
    tick; m0_req = 1'b0; m1_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_req, m0_gnt, m1_gnt} !== 3'b000) begin
      failures++; $display("FAIL handoff_drop req/gnt0/gnt1=%b exp=000", {s_req, m0_gnt, m1_gnt});
    end
    tick;
    @(negedge clk);
    checks++;
    if (m1_gnt !== 1'b1 || s_addr !== 32'h60) begin
      failures++; $display("FAIL handoff_own1 gnt=%b addr=%h exp=1 60", m1_gnt, s_addr);
    end
    tick;
    idle_all;
  endtask

  task automatic test_back_to_back;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h200;
    tick;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt0 gnt=%b exp=1", m0_gnt); end
    tick; m0_addr = 32'h204; s_rdata = 32'h0000_00A0;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m0_rvalid} !== 2'b11 || m0_rdata !== 32'hA0) begin
      failures++; $display("FAIL b2b_rd0 gnt/rvalid=%b rdata=%h exp=11 a0", {m0_gnt, m0_rvalid}, m0_rdata);
    end
    tick; m0_req = 1'b0; s_rdata = 32'h0000_00A1;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA1 || m1_rvalid !== 1'b0) begin
      failures++; $display("FAIL b2b_rd1 rvalid=%b rdata=%h m1_rvalid=%b exp=1 a1 0", m0_rvalid, m0_rdata, m1_rvalid);
    end
    tick;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_end rvalid=%b exp=0", m0_rvalid); end
    tick;
    idle_all;
  endtask

  task automatic test_reset_mid_read;
    // Solo M0 tenure first, so a stale last_owner would hand the next tie to M1.
    m0_req = 1'b1; m0_we = 1'b1;
    tick; tick; m0_req = 1'b0;
    tick;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h80;
    tick;
    @(negedge clk);
    checks++;
    if (m0_gnt !== 1'b1) begin failures++; $display("FAIL midrst_gnt gnt=%b exp=1", m0_gnt); end
    tick; m0_req = 1'b0; s_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    checks++;
    if ({m0_rvalid, m1_rvalid, s_req} !== 3'b000 || m0_rdata !== 32'h0) begin
      failures++; $display("FAIL midrst_drop rv0/rv1/req=%b rdata=%h exp=000 0", {m0_rvalid, m1_rvalid, s_req}, m0_rdata);
    end
    tick; n_rst = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m1_req = 1'b1; m1_we = 1'b1;
    @(negedge clk);
    checks++;
    if (s_req !== 1'b0) begin failures++; $display("FAIL midrst_idle s_req=%b exp=0", s_req); end
    tick;
    @(negedge clk);
    checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      failures++; $display("FAIL midrst_tie gnt0/gnt1=%b exp=10", {m0_gnt, m1_gnt});
    end
    tick;
    idle_all;
  endtask

  task automatic test_solo;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h100; m1_wdata = 32'h5A5A_0000;
    tick;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({m1_gnt, m0_gnt} !== 2'b10 || s_addr !== 32'h100 + 32'(4 * i)) begin
        failures++; $display("FAIL solo_cyc%0d gnt1/gnt0=%b addr=%h exp=10 %h",
                             i, {m1_gnt, m0_gnt}, s_addr, 32'h100 + 32'(4 * i));
      end
      tick;
      m1_addr = m1_addr + 32'd4;
    end
    m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m1_gnt !== 1'b0) begin failures++; $display("FAIL solo_end gnt=%b exp=0", m1_gnt); end
    tick;
    idle_all;
  endtask

  initial begin
    test_reset;
    test_single_read;
    test_contention;
    test_stall;
    test_handoff;
    test_back_to_back;
    test_reset_mid_read;
    test_solo;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-master arbiter that shares the single data-memory bus (the path into MemController, and from there to RAM, UART and GPIO) between the RISC-V core (master 0) and a UART program loader / DMA engine (master 1). It owns a registered state machine that picks a bus owner, forwards the owner's request to the slave side, and routes one-cycle-latency read data back to the master that issued it. A burst cap alternates ownership fairly under contention.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, address width
- MAX_BURST, 4, max accepted transfers per tenure while the other master waits (≥1)

- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  master request, held until granted
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  ADDR_WIDTH  byte address
- m0_wdata / m1_wdata  in  DATA_WIDTH  write data
- m0_gnt / m1_gnt  out  1  transfer accepted this cycle
- m0_rvalid / m1_rvalid  out  1  read data valid this cycle
- m0_rdata / m1_rdata  out  DATA_WIDTH  read data, 0 when rvalid low
- s_req  out  1  request to slave side
- s_we  out  1  write strobe to slave side
- s_addr  out  ADDR_WIDTH  address to slave side
- s_wdata  out  DATA_WIDTH  write data to slave side
- s_ready  in  1  slave accepts transfer this cycle
- s_rdata  in  DATA_WIDTH  slave read data, valid cycle after read acceptance

## Operation
- States: IDLE, OWN0, OWN1; registered. Reset -> IDLE.
- Acceptance: transfer completes in any cycle where s_req & s_ready; mX_gnt = (state==OWNX) & mX_req & s_ready.
- s_req/s_we/s_addr/s_wdata = owner's signals in OWNx; all zero in IDLE.
- IDLE: only m0_req -> OWN0; only m1_req -> OWN1; both -> master opposite to last_owner. last_owner resets to 1 (M0 wins first tie).
- OWNx, owner req low -> OWNy if other req high, else IDLE; last_owner <= x.
- OWNx, burst_cnt counts accepted transfers in tenure; on the acceptance that makes burst_cnt == MAX_BURST with other req high -> OWNy. Other req low: tenure unlimited, counter saturates at MAX_BURST.
- burst_cnt clears on every ownership change.
- Reads: on read acceptance, rd_pend <= 1, rd_id <= owner. Next cycle mX_rvalid = rd_pend & rd_id==X; mX_rdata = s_rdata when valid, else 0. Back-to-back reads legal (one in flight per cycle).
- Writes: no response; gnt is the completion.
- Masters hold req/we/addr/wdata stable until gnt; dropping req before gnt aborts, no slave effect.
- Reset mid-operation: state -> IDLE, burst_cnt 0, rd_pend 0 (in-flight read dropped, no rvalid), last_owner 1.

## Timing
- Reset values: all gnt, rvalid, s_req, s_we = 0; s_addr, s_wdata, mX_rdata = 0.
- Request from IDLE at cycle N -> s_req and possible gnt at N+1 (one cycle arbitration latency).
- Held ownership: back-to-back gnt every cycle s_ready is high, zero bubbles.
- Hand-off: owner drops req at N -> other master's s_req at N+1; forced switch on MAX_BURST acceptance at N -> other owns at N+1.
- Read data: acceptance at N -> rvalid at N+1 only.
- s_ready low: gnt low, state and counter hold.

## Structure
- Shared package arb_pkg: state encoding (ARB_IDLE, ARB_OWN0, ARB_OWN1), master IDs MID_CORE=0, MID_LOADER=1.
- One sub-module: arb_rd_tracker (rd_pend/rd_id register plus return demux to rvalid/rdata).
- Arbiter FSM, burst counter and slave-side mux stay in top module.

## Test plan
- Reset: hold n_rst=0 with both reqs high -> all outputs 0; release -> M0 owns next cycle, m0_gnt=1 with s_ready=1.
- Single read: m1 read 0x0000_0010, s_ready=1, s_rdata=0xDEAD_BEEF next cycle -> m1_gnt at N+1, m1_rvalid=1/m1_rdata=0xDEAD_BEEF at N+2, m0_rvalid=0.
- Contention: both reqs continuous, MAX_BURST=4 -> gnt pattern 4×M0, 4×M1, 4×M0, no gaps.
- Stall: owner write with s_ready low 3 cycles -> no gnt, s_addr/s_wdata stable, gnt on 4th cycle, burst_cnt unchanged while stalled.
- Reset mid-read: read accepted at N, n_rst low at N+0.5 -> no rvalid, state IDLE, next tie goes to M0.
- Solo master: only M1 requests 10 transfers -> 10 consecutive gnt, no forced hand-off.
